// File: rtl/wdata_packer_pkg.sv
// Shared constants, FSM encoding and strobe-mask helpers for the write-data packer.
package wdata_packer_pkg;
  localparam int AXI_LEN_W   = 8;
  localparam int BOUNDARY_4K = 4096;
  localparam int MAX_LANES   = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  function automatic logic [MAX_LANES-1:0] lanes_from(input int lane);
    for (int i = 0; i < MAX_LANES; i++) lanes_from[i] = (i >= lane);
  endfunction

  function automatic logic [MAX_LANES-1:0] lanes_upto(input int lane);
    for (int i = 0; i < MAX_LANES; i++) lanes_upto[i] = (i <= lane);
  endfunction
endpackage

// File: rtl/wdata_packer_if.sv
// Source byte-stream port plus AXI write address/data channels of the packer.
interface wdata_packer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic                  dbus_valid;
  logic [DATA_W-1:0]     dbus_wdata;
  logic                  dbus_ready;
  logic                  dma_aw_valid;
  logic [ADDR_W-1:0]     dma_aw_addr;
  logic [LEN_W-1:0]      dma_aw_len;
  logic                  dma_aw_ready;
  logic                  dma_w_valid;
  logic [DATA_W-1:0]     dma_w_wdata;
  logic [DATA_W/8-1:0]   dma_w_wstrb;
  logic                  dma_w_last;
  logic                  dma_w_ready;

  modport master (
    input  dbus_valid, dbus_wdata, dma_aw_ready, dma_w_ready,
    output dbus_ready, dma_aw_valid, dma_aw_addr, dma_aw_len,
           dma_w_valid, dma_w_wdata, dma_w_wstrb, dma_w_last
  );

  modport slave (
    output dbus_valid, dbus_wdata, dma_aw_ready, dma_w_ready,
    input  dbus_ready, dma_aw_valid, dma_aw_addr, dma_aw_len,
           dma_w_valid, dma_w_wdata, dma_w_wstrb, dma_w_last
  );
endinterface

// File: rtl/wdata_packer_burst_splitter.sv
// Burst length = min(remaining beats, MAX_BURST, beats left before the next 4 KiB line).
module burst_splitter
  import wdata_packer_pkg::*;
#(
  parameter int BEATS_W   = 33,
  parameter int LEN_W     = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256
) (
  input  logic [11:0]        addr_lo,
  input  logic [BEATS_W-1:0] beats,
  output logic [LEN_W:0]     burst_beats
);
  localparam int OFF = $clog2(DATA_W / 8);

  logic [12:0]        to_bound;
  logic [BEATS_W-1:0] lim;

  always_comb begin
    to_bound = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> OFF;
    lim      = beats;
    if (BEATS_W'(to_bound) < lim)  lim = BEATS_W'(to_bound);
    if (BEATS_W'(MAX_BURST) < lim) lim = BEATS_W'(MAX_BURST);
    burst_beats = (LEN_W+1)'(lim);
  end
endmodule

// File: rtl/wdata_packer.sv
// Realigns a contiguous byte stream onto DATA_W-aligned AXI write bursts,
// splitting at MAX_BURST and 4 KiB boundaries.
module wdata_packer
  import wdata_packer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = AXI_LEN_W,
  parameter int MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              done,
  wdata_packer_if.master    bus
);
  localparam int N   = DATA_W / 8;
  localparam int OFF = $clog2(N);
  localparam int CW  = ADDR_W + 1;

  state_t              state;
  logic [OFF-1:0]      off_q, end_lane_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       beats_left, words_left;
  logic [LEN_W:0]      burst_left;
  logic                first_q;
  logic [DATA_W-1:0]   carry_q;
  logic                aw_valid_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [LEN_W-1:0]    aw_len_q;
  logic                vld_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [N-1:0]        wstrb_p1;
  logic                wlast_p1;

  logic [CW-1:0]       span, beats_calc, words_calc, split_beats;
  logic [ADDR_W-1:0]   start_aligned, split_addr;
  logic [LEN_W:0]      split_len;
  logic                have_word, w_hs, load;
  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]   beat_data, carry_nxt;
  logic [N-1:0]        beat_strb;

  assign span          = {1'b0, end_addr} - {1'b0, start_addr} + CW'(1);
  assign beats_calc    = CW'(end_addr >> OFF) - CW'(start_addr >> OFF) + CW'(1);
  assign words_calc    = (span + CW'(N - 1)) >> OFF;
  assign start_aligned = {start_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign split_addr    = (state == ST_IDLE) ? start_aligned : addr_q;
  assign split_beats   = (state == ST_IDLE) ? beats_calc : beats_left;

  burst_splitter #(
    .BEATS_W(CW), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) u_split (
    .addr_lo(split_addr[11:0]), .beats(split_beats), .burst_beats(split_len)
  );

  assign have_word = (words_left != '0);
  assign w_hs      = vld_p1 && bus.dma_w_ready;
  assign load      = rst && !clear && (state == ST_DATA) && (burst_left != '0) &&
                     (!vld_p1 || bus.dma_w_ready) && (!have_word || bus.dbus_valid);
  assign bus.dbus_ready = load && have_word;

  // Input word lands at lane offset; its spilled upper bytes become the next carry.
  assign shifted   = {{DATA_W{1'b0}}, bus.dbus_wdata} << {off_q, 3'b000};
  assign beat_data = have_word ? (shifted[DATA_W-1:0] | carry_q) : carry_q;
  assign carry_nxt = have_word ? shifted[2*DATA_W-1:DATA_W] : '0;

  always_comb begin
    beat_strb = '1;
    if (first_q)                 beat_strb &= N'(lanes_from(int'(off_q)));
    if (beats_left == CW'(1))    beat_strb &= N'(lanes_upto(int'(end_lane_q)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      off_q      <= '0;
      end_lane_q <= '0;
      addr_q     <= '0;
      beats_left <= '0;
      words_left <= '0;
      burst_left <= '0;
      first_q    <= 1'b0;
      carry_q    <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      vld_p1     <= 1'b0;
      wdata_p1   <= '0;
      wstrb_p1   <= '0;
      wlast_p1   <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      beats_left <= '0;
      words_left <= '0;
      burst_left <= '0;
      carry_q    <= '0;
      aw_valid_q <= 1'b0;
      vld_p1     <= 1'b0;
      wlast_p1   <= 1'b0;
    end else begin
      done <= 1'b0;
      // Output stage p1: one-entry beat register feeding the W channel.
      if (load) begin
        vld_p1     <= 1'b1;
        wdata_p1   <= beat_data;
        wstrb_p1   <= beat_strb;
        wlast_p1   <= (burst_left == (LEN_W+1)'(1));
        carry_q    <= carry_nxt;
        addr_q     <= addr_q + ADDR_W'(N);
        beats_left <= beats_left - CW'(1);
        burst_left <= burst_left - (LEN_W+1)'(1);
        first_q    <= 1'b0;
        if (have_word) words_left <= words_left - CW'(1);
      end else if (w_hs) begin
        vld_p1 <= 1'b0;
      end

      case (state)
        ST_IDLE: if (run) begin
          off_q      <= start_addr[OFF-1:0];
          end_lane_q <= end_addr[OFF-1:0];
          addr_q     <= start_aligned;
          beats_left <= beats_calc;
          words_left <= words_calc;
          carry_q    <= '0;
          first_q    <= 1'b1;
          if (end_addr < start_addr) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state      <= ST_ADDR;
            aw_valid_q <= 1'b1;
            aw_addr_q  <= split_addr;
            aw_len_q   <= LEN_W'(split_len - (LEN_W+1)'(1));
            burst_left <= split_len;
          end
        end
        ST_ADDR: if (aw_valid_q && bus.dma_aw_ready) begin
          aw_valid_q <= 1'b0;
          state      <= ST_DATA;
        end
        // Burst ends only once its last beat has left, so the next AW never overtakes it.
        ST_DATA: if (w_hs && wlast_p1) begin
          if (beats_left != '0) begin
            state      <= ST_ADDR;
            aw_valid_q <= 1'b1;
            aw_addr_q  <= split_addr;
            aw_len_q   <= LEN_W'(split_len - (LEN_W+1)'(1));
            burst_left <= split_len;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dma_aw_valid = aw_valid_q;
  assign bus.dma_aw_addr  = aw_addr_q;
  assign bus.dma_aw_len   = aw_len_q;
  assign bus.dma_w_valid  = vld_p1;
  assign bus.dma_w_wdata  = wdata_p1;
  assign bus.dma_w_wstrb  = wstrb_p1;
  assign bus.dma_w_last   = wlast_p1;
endmodule
